// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the timing generator and the pixel/game logic.
// Latency: none, this is wiring only.
// Backpressure: none; pix_en is the only consumer-side control and acts as a clock enable.
// Ports: pix_en (in to generator); xCount/yCount position; displayArea/blank_n/VGA_hSync/VGA_vSync
//        delayed video timing; line_start/frame_start/vblank_start single-cycle strobes.
interface vga_timing_gen_if #(
   parameter int CW = 10
);
   logic          pix_en;
   logic [CW-1:0] xCount;
   logic [CW-1:0] yCount;
   logic          displayArea;
   logic          blank_n;
   logic          VGA_hSync;
   logic          VGA_vSync;
   logic          line_start;
   logic          frame_start;
   logic          vblank_start;

   modport master (
      input  pix_en,
      output xCount, yCount, displayArea, blank_n, VGA_hSync, VGA_vSync,
             line_start, frame_start, vblank_start
   );

   modport slave (
      output pix_en,
      input  xCount, yCount, displayArea, blank_n, VGA_hSync, VGA_vSync,
             line_start, frame_start, vblank_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters with sync/blank decode and frame strobes.
// Latency: sync/blank/displayArea lag xCount/yCount by PIPE_DLY enabled cycles; strobes 1 clock.
// Backpressure: none; everything advances only when pix_en=1 and holds otherwise.
// Ports: VGA_clk, reset_n (sync, active-low); vga (master modport of vga_timing_gen_if).
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int PIPE_DLY = 1,
   parameter int CW       = 10
) (
   input  logic             VGA_clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Decode boundaries; sync end is always below TOTAL because the back porch is >= 1.
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          H_ON   = 1'(H_POL);
   localparam logic          V_ON   = 1'(V_POL);

   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic          x_wrap;
   logic          de_raw, hs_raw, vs_raw;
   logic          line_start_q, frame_start_q, vblank_start_q;
   logic          line_start_d, frame_start_d, vblank_start_d;

   // Pipeline stage bits are {de, hs, vs}; all-zero is the blank / sync-inactive value.
   logic [2:0]    pipe_q [PIPE_DLY];
   logic [2:0]    pipe_out;

   // Counter next state: x wraps at H_LAST, y steps only on an x wrap.
   always_comb begin
      x_wrap = (x_q == H_LAST);
      x_d    = x_wrap ? '0 : x_q + CW'(1);
      y_d    = y_q;
      if (x_wrap) begin
         y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
      end
   end

   // Strobes describe the position about to be loaded, so they land together with it.
   always_comb begin
      line_start_d   = vga.pix_en & x_wrap;
      frame_start_d  = vga.pix_en & x_wrap & (y_d == '0);
      vblank_start_d = vga.pix_en & x_wrap & (y_d == V_ACT);
   end

   always_comb begin
      de_raw = (x_q < H_ACT) && (y_q < V_ACT);
      hs_raw = (x_q >= HS_BEG) && (x_q < HS_END);
      vs_raw = (y_q >= VS_BEG) && (y_q < VS_END);
   end

   always_ff @(posedge VGA_clk) begin
      if (!reset_n) begin
         x_q            <= '0;
         y_q            <= '0;
         line_start_q   <= 1'b0;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
      end else begin
         line_start_q   <= line_start_d;
         frame_start_q  <= frame_start_d;
         vblank_start_q <= vblank_start_d;
         if (vga.pix_en) begin
            x_q <= x_d;
            y_q <= y_d;
         end
      end
   end

   // Decode of the current position enters stage 0; a reset flushes every stage to blank.
   always_ff @(posedge VGA_clk) begin
      if (!reset_n) begin
         for (int i = 0; i < PIPE_DLY; i++) begin
            pipe_q[i] <= 3'b000;
         end
      end else if (vga.pix_en) begin
         pipe_q[0] <= {de_raw, hs_raw, vs_raw};
         for (int i = 1; i < PIPE_DLY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign pipe_out = pipe_q[PIPE_DLY-1];

   assign vga.xCount       = x_q;
   assign vga.yCount       = y_q;
   assign vga.displayArea  = pipe_out[2];
   assign vga.blank_n      = pipe_out[2];
   assign vga.VGA_hSync    = pipe_out[1] ? H_ON : ~H_ON;
   assign vga.VGA_vSync    = pipe_out[0] ? V_ON : ~V_ON;
   assign vga.line_start   = line_start_q;
   assign vga.frame_start  = frame_start_q;
   assign vga.vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator instances (default 640x480, small PIPE_DLY=4, tiny positive-sync).
// A linear-position reference model predicts every output on every cycle.
// Inputs change on the falling edge; outputs are compared on the falling edge before new inputs.
module tb_vga_timing_gen;

   localparam int NI = 3;
   localparam int HA [NI] = '{640, 16, 8};
   localparam int HF [NI] = '{16,  4,  2};
   localparam int HS [NI] = '{96,  6,  3};
   localparam int HB [NI] = '{48,  4,  2};
   localparam int VA [NI] = '{480, 10, 4};
   localparam int VF [NI] = '{10,  2,  1};
   localparam int VS [NI] = '{2,   2,  1};
   localparam int VB [NI] = '{33,  3,  1};
   localparam int HP [NI] = '{0,   0,  1};
   localparam int VP [NI] = '{0,   0,  1};
   localparam int PD [NI] = '{1,   4,  2};
   localparam int NCYC = 6000;

   logic clk;
   logic rst [NI];
   logic pen [NI];

   vga_timing_gen_if #(.CW(10)) if0 ();
   vga_timing_gen_if #(.CW(6))  if1 ();
   vga_timing_gen_if #(.CW(4))  if2 ();

   assign if0.pix_en = pen[0];
   assign if1.pix_en = pen[1];
   assign if2.pix_en = pen[2];

   vga_timing_gen u0 (.VGA_clk(clk), .reset_n(rst[0]), .vga(if0.master));

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .H_POL(0), .V_POL(0), .PIPE_DLY(4), .CW(6)
   ) u1 (.VGA_clk(clk), .reset_n(rst[1]), .vga(if1.master));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1), .V_POL(1), .PIPE_DLY(2), .CW(4)
   ) u2 (.VGA_clk(clk), .reset_n(rst[2]), .vga(if2.master));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   // pos = y*H_TOTAL + x. samp remembers the position held at each enabled edge since reset;
   // the delayed outputs at enable count n belong to the position sampled at enable n-PIPE_DLY.
   int  pos     [NI];
   int  nen     [NI];
   int  samp    [NI][16];
   bit  e_ls    [NI];
   bit  e_fs    [NI];
   bit  e_vb    [NI];
   int  en_since;
   bit  fs_valid;

   function automatic int htot(int k);
      return HA[k] + HF[k] + HS[k] + HB[k];
   endfunction

   function automatic int vtot(int k);
      return VA[k] + VF[k] + VS[k] + VB[k];
   endfunction

   // {de, hs, vs} for a linear position; p < 0 means "nothing sampled yet" -> blank, no sync.
   function automatic logic [2:0] dec(int k, int p);
      int x, y;
      logic de, hs, vs;
      if (p < 0) return 3'b000;
      x  = p % htot(k);
      y  = p / htot(k);
      de = (x < HA[k]) && (y < VA[k]);
      hs = (x >= HA[k] + HF[k]) && (x < HA[k] + HF[k] + HS[k]);
      vs = (y >= VA[k] + VF[k]) && (y < VA[k] + VF[k] + VS[k]);
      return {de, hs, vs};
   endfunction

   initial begin
      for (int k = 0; k < NI; k++) begin
         pos[k] = 0; nen[k] = 0; e_ls[k] = 0; e_fs[k] = 0; e_vb[k] = 0;
      end
      en_since = 0;
      fs_valid = 0;
   end

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         e_ls[k] = 1'b0; e_fs[k] = 1'b0; e_vb[k] = 1'b0;
         if (!rst[k]) begin
            pos[k] = 0;
            nen[k] = 0;
            if (k == 1) begin en_since = 0; fs_valid = 0; end
         end else if (pen[k]) begin
            samp[k][nen[k] % 16] = pos[k];
            nen[k]  = nen[k] + 1;
            pos[k]  = (pos[k] + 1) % (htot(k) * vtot(k));
            e_ls[k] = (pos[k] % htot(k)) == 0;
            e_fs[k] = pos[k] == 0;
            e_vb[k] = pos[k] == VA[k] * htot(k);
            if (k == 1) en_since = en_since + 1;
         end
      end
   end

   // ---------------- checking ----------------
   int passes, checks, cyc;
   int dx [NI], dy [NI];
   bit dde [NI], dbl [NI], dhs [NI], dvs [NI], dls [NI], dfs [NI], dvb [NI];

   task automatic chk(string nm, int k, int got, int want);
      checks++;
      if (got == want) passes++;
      else $display("FAIL %s u%0d cyc%0d got %0d want %0d", nm, k, cyc, got, want);
   endtask

   task automatic sample_dut();
      dx[0] = int'(if0.xCount); dy[0] = int'(if0.yCount);
      dx[1] = int'(if1.xCount); dy[1] = int'(if1.yCount);
      dx[2] = int'(if2.xCount); dy[2] = int'(if2.yCount);
      dde[0] = if0.displayArea; dbl[0] = if0.blank_n; dhs[0] = if0.VGA_hSync; dvs[0] = if0.VGA_vSync;
      dde[1] = if1.displayArea; dbl[1] = if1.blank_n; dhs[1] = if1.VGA_hSync; dvs[1] = if1.VGA_vSync;
      dde[2] = if2.displayArea; dbl[2] = if2.blank_n; dhs[2] = if2.VGA_hSync; dvs[2] = if2.VGA_vSync;
      dls[0] = if0.line_start;  dfs[0] = if0.frame_start; dvb[0] = if0.vblank_start;
      dls[1] = if1.line_start;  dfs[1] = if1.frame_start; dvb[1] = if1.vblank_start;
      dls[2] = if2.line_start;  dfs[2] = if2.frame_start; dvb[2] = if2.vblank_start;
   endtask

   task automatic compare_all();
      logic [2:0] d;
      int p;
      for (int k = 0; k < NI; k++) begin
         p = (nen[k] >= PD[k]) ? samp[k][(nen[k] - PD[k]) % 16] : -1;
         d = dec(k, p);
         chk("xCount",       k, dx[k],  pos[k] % htot(k));
         chk("yCount",       k, dy[k],  pos[k] / htot(k));
         chk("displayArea",  k, dde[k], d[2]);
         chk("blank_n",      k, dbl[k], d[2]);
         chk("hSync",        k, dhs[k], d[1] ? HP[k] : 1 - HP[k]);
         chk("vSync",        k, dvs[k], d[0] ? VP[k] : 1 - VP[k]);
         chk("line_start",   k, dls[k], e_ls[k]);
         chk("frame_start",  k, dfs[k], e_fs[k]);
         chk("vblank_start", k, dvb[k], e_vb[k]);
      end
   endtask

   // Directed / event-level bookkeeping
   bit prev_hs0;
   int hs_run0, bl_cnt0;
   bit ls_seen0;
   int rst_left [NI];
   int dir_state;
   bit lit_pending;

   initial begin
      passes = 0; checks = 0; cyc = 0;
      prev_hs0 = 1'b1; hs_run0 = 0; bl_cnt0 = 0; ls_seen0 = 0;
      dir_state = 0; lit_pending = 0;
      for (int k = 0; k < NI; k++) begin
         rst[k] = 1'b0; pen[k] = 1'b1; rst_left[k] = 3;
      end

      // Hand-computed anchors for the model at default timing.
      chk("model_htot",  0, htot(0), 800);
      chk("model_vtot",  0, vtot(0), 525);
      chk("model_frame", 0, htot(0) * vtot(0), 420000);
      chk("model_hs656", 0, int'(dec(0, 656)), 3'b010);
      chk("model_hs655", 0, int'(dec(0, 655)), 3'b000);
      chk("model_hs751", 0, int'(dec(0, 751)), 3'b010);
      chk("model_hs752", 0, int'(dec(0, 752)), 3'b000);
      chk("model_vs490", 0, int'(dec(0, 490 * 800)), 3'b001);
      chk("model_de639", 0, int'(dec(0, 479 * 800 + 639)), 3'b100);
      chk("model_tiny",  2, htot(2) * vtot(2), 105);

      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         sample_dut();
         compare_all();

         // Reset-state literals while every instance is still held in reset.
         if (cyc == 1) begin
            chk("rst_hsync_neg", 0, dhs[0], 1);
            chk("rst_vsync_neg", 0, dvs[0], 1);
            chk("rst_hsync_pos", 2, dhs[2], 0);
            chk("rst_vsync_pos", 2, dvs[2], 0);
            chk("rst_blank",     1, dbl[1], 0);
         end

         // First cycle after the directed mid-sync reset of u1.
         if (lit_pending) begin
            lit_pending = 0;
            chk("post_rst_x",     1, dx[1],  1);
            chk("post_rst_y",     1, dy[1],  0);
            chk("post_rst_blank", 1, dbl[1], 0);
            chk("post_rst_hs",    1, dhs[1], 1);
            chk("post_rst_vs",    1, dvs[1], 1);
            chk("post_rst_fs",    1, dfs[1], 0);
         end

         // u0: hsync low run of 96 starting one clock after xCount=656; 640 visible clocks per line.
         if (cyc > 4) begin
            if (prev_hs0 && !dhs[0]) chk("hs_fall_x", 0, dx[0], 657);
            if (!prev_hs0 && dhs[0]) begin
               chk("hs_width", 0, hs_run0, 96);
               hs_run0 = 0;
            end
            if (!dhs[0]) hs_run0++;
            if (dls[0]) begin
               if (ls_seen0) chk("blank_per_line", 0, bl_cnt0, 640);
               ls_seen0 = 1;
               bl_cnt0  = 0;
            end
            if (dbl[0]) bl_cnt0++;
            prev_hs0 = dhs[0];
         end

         // u1: enabled edges between consecutive frame_starts equal one frame.
         if (dfs[1]) begin
            if (fs_valid) chk("frame_period", 1, en_since, 510);
            fs_valid = 1;
            en_since = 0;
         end

         // ---------------- drive next inputs ----------------
         // u0: free-running pixel clock, released once.
         rst[0] = (rst_left[0] == 0);
         if (rst_left[0] > 0) rst_left[0]--;
         pen[0] = 1'b1;

         // u1: random enable, rare random resets, one directed reset inside h+v sync.
         if (dir_state == 0 && cyc > 200 && pos[1] == 12 * 30 + 21 && rst_left[1] == 0) begin
            dir_state   = 1;
            rst_left[1] = 3;
         end else if (rst_left[1] == 0 && cyc > 1500 && $urandom_range(0, 599) == 0) begin
            rst_left[1] = $urandom_range(1, 4);
         end
         rst[1] = (rst_left[1] == 0);
         if (rst_left[1] > 0) rst_left[1]--;
         pen[1] = ($urandom_range(0, 3) != 0);
         if (dir_state == 1 && rst[1]) begin
            pen[1]      = 1'b1;
            dir_state   = 2;
            lit_pending = 1;
         end

         // u2: master-clock mode with the enable toggling 1,0,1,0; rare resets.
         if (rst_left[2] == 0 && cyc > 300 && $urandom_range(0, 799) == 0)
            rst_left[2] = $urandom_range(1, 3);
         rst[2] = (rst_left[2] == 0);
         if (rst_left[2] > 0) rst_left[2]--;
         pen[2] = (cyc % 2) == 0;
      end

      if (dir_state != 2) begin
         checks++;
         $display("FAIL directed_reset u1 never reached sync position (state %0d, want 2)", dir_state);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
